led_row_scanner: RTL

LED_ROW_SCANNER -- requirements
Module: led_row_scanner

---
 rtl/led_row_scanner_if.sv | 10 +
 rtl/led_row_scanner.sv | 68 ++++++
 2 files changed

// File: rtl/led_row_scanner_if.sv
// led_row_scanner_if: board input and row/column drive outputs of the LED row scanner
interface led_row_scanner_if;
  logic [15:0][15:0] board;
  logic [3:0]        row_sel;
  logic              row_en;
  logic [15:0]       col_data;
  logic              frame_start;
  modport master(input board, output row_sel, row_en, col_data, frame_start);
  modport slave(output board, input row_sel, row_en, col_data, frame_start);
endinterface

// File: rtl/led_row_scanner.sv
// led_row_scanner: blank/on row scan of a 16x16 board; SCAN_FRAME_SYNC_EN adds a tear-free frame snapshot
module led_row_scanner #(
  parameter int DWELL = 4,
  parameter int BLANK = 2
) (
  input logic CLOCK_50,
  input logic reset,
  led_row_scanner_if.master bus
);
  localparam int MX = DWELL > BLANK ? DWELL : BLANK;
  localparam int W = MX > 1 ? $clog2(MX) : 1;
  localparam logic [W-1:0] DW = W'(DWELL - 1);
  localparam logic [W-1:0] BL = W'(BLANK - 1);
  typedef enum logic {S_BLANK, S_ON} state_t;
  state_t      state;
  logic [W-1:0] timer;
  logic [3:0]  row_sel;
  logic        row_en;
  logic [15:0] col_data;
  logic        frame_start;
  logic [15:0] src_row;
  logic        wrap;
  assign wrap = state == S_ON && timer == '0 && row_sel == 4'hF;
`ifdef SCAN_FRAME_SYNC_EN
  logic [15:0][15:0] snap;
  logic              first;
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      snap  <= '0;
      first <= 1'b1;
    end else begin
      first <= 1'b0;
      if (first || wrap) snap <= bus.board;
    end
  assign src_row = snap[row_sel];
`else
  assign src_row = bus.board[row_sel];
`endif
  // timer holds the remaining cycles of the current phase minus one
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      state       <= S_BLANK;
      timer       <= BL;
      row_sel     <= '0;
      row_en      <= 1'b0;
      col_data    <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (timer != '0) timer <= timer - W'(1);
      else if (state == S_BLANK) begin
        state    <= S_ON;
        timer    <= DW;
        row_en   <= 1'b1;
        col_data <= src_row;
      end else begin
        state       <= S_BLANK;
        timer       <= BL;
        row_en      <= 1'b0;
        row_sel     <= row_sel + 4'd1;
        frame_start <= wrap;
      end
    end
  assign bus.row_sel     = row_sel;
  assign bus.row_en      = row_en;
  assign bus.col_data    = col_data;
  assign bus.frame_start = frame_start;
endmodule
